// File: rtl/ghash_digit_serial_core.sv
// GHASH accumulator Y_i = (Y_{i-1} ^ X_i) * H over GF(2^128) with a digit-serial multiplier.
// Optional macro GHASH_BUSY_ERROR_EN adds a sticky o_error flag for blocks offered while busy.
module ghash_digit_serial_core #(
    parameter int unsigned NB_DATA  = 128,
    parameter int unsigned NB_DIGIT = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data_x,
    input  logic [NB_DATA-1:0] i_h_key,
    input  logic               i_valid,
    input  logic               i_start,
    input  logic               i_last,
    output logic               o_ready,
    output logic [NB_DATA-1:0] o_data_y,
    output logic               o_valid
`ifdef GHASH_BUSY_ERROR_EN
    ,
    output logic               o_error
`endif
);

    localparam int unsigned N_DIGITS = NB_DATA / NB_DIGIT;
    localparam int unsigned NB_CNT   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [NB_DATA-1:0] R_POLY = {8'hE1, {(NB_DATA-8){1'b0}}};
    localparam logic [NB_CNT-1:0]  CNT_LAST = NB_CNT'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NB_DATA-1:0]  a_q, a_d;
    logic [NB_DATA-1:0]  z_q, z_d;
    logic [NB_DATA-1:0]  v_q, v_d;
    logic [NB_DATA-1:0]  h_q, h_d;
    logic [NB_DATA-1:0]  acc_q, acc_d;
    logic [NB_CNT-1:0]   cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                ready_d, valid_d;
    logic [NB_DATA-1:0]  data_y_d;
    logic                accept;
    logic [NB_DATA-1:0]  a_work, z_work, v_work;

    assign accept = i_valid & o_ready;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        z_d      = z_q;
        v_d      = v_q;
        h_d      = h_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        a_work   = a_q;
        z_work   = z_q;
        v_work   = v_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = (i_start ? '0 : acc_q) ^ i_data_x;
                    h_d     = i_start ? i_h_key : h_q;
                    v_d     = i_start ? i_h_key : h_q;
                    z_d     = '0;
                    last_d  = i_last;
                    cnt_d   = '0;
                    state_d = ST_MULT;
                end
            end
            ST_MULT: begin
                // Leading bit of a_work is the next coefficient, x^0 first.
                for (int unsigned j = 0; j < NB_DIGIT; j++) begin
                    if (a_work[NB_DATA-1]) begin
                        z_work = z_work ^ v_work;
                    end
                    v_work = v_work[0] ? ((v_work >> 1) ^ R_POLY) : (v_work >> 1);
                    a_work = a_work << 1;
                end
                a_d   = a_work;
                z_d   = z_work;
                v_d   = v_work;
                cnt_d = cnt_q + NB_CNT'(1);
                if (cnt_q == CNT_LAST) begin
                    acc_d   = z_work;
                    cnt_d   = '0;
                    state_d = last_q ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d  = (state_d == ST_IDLE);
        valid_d  = (state_d == ST_DONE);
        data_y_d = (state_d == ST_DONE) ? acc_d : o_data_y;
    end

    // State and registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            z_q      <= '0;
            v_q      <= '0;
            h_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            o_ready  <= 1'b0;
            o_valid  <= 1'b0;
            o_data_y <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            z_q      <= z_d;
            v_q      <= v_d;
            h_q      <= h_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            o_ready  <= ready_d;
            o_valid  <= valid_d;
            o_data_y <= data_y_d;
        end
    end

`ifdef GHASH_BUSY_ERROR_EN
    // Sticky flag: a block was offered while the core could not take it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_error <= 1'b0;
        end else begin
            o_error <= o_error | (i_valid & ~o_ready);
        end
    end
`endif

endmodule

// File: doc/ghash_digit_serial_core.md
Name: ghash_digit_serial_core

Overview:
- Sequential GHASH accumulator for the GCM authentication path. Sits around the GF(2^128) multiply stage.
- Consumes 128-bit blocks X_i and computes Y_i = (Y_{i-1} XOR X_i) * H in GF(2^128).
- Uses an internal digit-serial multiplier, NB_DIGIT bits per clock.
- Serves as the area-lean alternative to the fully parallel KOA multiplier. Output is the final GHASH value, handed to the tag XOR stage.

Parameters:
- NB_DATA, 128, block width; only 128 is supported.
- NB_DIGIT, 8, multiplier bits consumed per cycle; must divide NB_DATA (1,2,4,8,16,32).

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_data_x  in  NB_DATA  input block X_i; i_data_x[127:120] is the first GCM byte
- i_h_key  in  NB_DATA  hash subkey H; sampled only on an accepted block with i_start=1
- i_valid  in  1  block valid
- i_start  in  1  first block of message; clears the accumulator and loads H
- i_last  in  1  final block of message
- o_ready  out  1  core can accept a block this cycle
- o_data_y  out  NB_DATA  GHASH result; stable until the next o_valid
- o_valid  out  1  one-cycle pulse, o_data_y holds the final GHASH

Behaviour:
- Bit order is GCM: bit 127 of each operand is the coefficient of x^0. Reduction constant R = 0xE1 followed by 120 zeros.
- Reset: state=IDLE, accumulator=0, H reg=0, o_ready=0 during the reset cycle then 1, o_valid=0, o_data_y=0.
- Accept: i_valid & o_ready.
  - Operand A = (i_start ? 0 : acc) XOR i_data_x.
  - H reg <= i_start ? i_h_key : H reg.
  - Latch i_last.
  - Z=0, V=H (the newly loaded H when i_start=1).
  - Go to MULT.
- FSM:
  - IDLE: o_ready=1. Accept -> MULT.
  - MULT: o_ready=0. Runs NB_DATA/NB_DIGIT cycles (16 at default). Each cycle processes the next NB_DIGIT bits of A, MSB (x^0) first. Per bit: if bit, Z ^= V; then V = V[0] ? (V>>1) XOR R : V>>1. A digit counter tracks progress.
    - After the last digit: acc <= Z.
    - Then -> DONE if latched last, else -> IDLE.
  - DONE: o_valid=1 for exactly one cycle, o_data_y <= acc. Then -> IDLE. o_ready=0 in DONE.
- Latency: accept at cycle t, result in acc at end of cycle t+NB_DATA/NB_DIGIT. o_valid asserted at cycle t+NB_DATA/NB_DIGIT+1. Peak throughput is 1 block per (NB_DATA/NB_DIGIT + 1) cycles.
- i_valid while o_ready=0 is ignored; the block is not consumed and the source must hold it.
- i_start and i_last may both be 1 on the same block (single-block message).
- Block without i_start after a completed message: chains from acc, which still holds the previous result. Sources must assert i_start on the first block.
- Reset mid-MULT or in DONE: abort immediately, all state to reset values, no o_valid.
- o_data_y updates only in DONE.

Optional Feature:
- Macro GHASH_BUSY_ERROR_EN.
- When defined, adds output port o_error (1 bit, reset 0). It is a sticky flag set when i_valid=1 while o_ready=0, and is cleared only by i_reset.
- When undefined, there is no o_error port and no extra logic; such i_valid is silently ignored as above.

Test Plan:
- Single block: H=66e94bd4ef8a2c3b884cfa59ca342b2e, X=0388dace60b6a392f328c2b971b2fe78, start=last=1 -> o_valid at accept+17, o_data_y=5e2ec746917062882c85b0685353deb7.
- Two blocks: same H; X1 as above with start=1; X2=00000000000000000000000000000080 with last=1 -> single o_valid, o_data_y=f38cbb1ad69223dcc3457ae5b6b0f885.
- Back-to-back: hold i_valid=1 across both blocks of the two-block case -> second block accepted exactly 17 cycles after the first; o_ready low 16 cycles; same result.
- Zero/identity: H=80000000000000000000000000000000 (multiplicative one), X=random, start=last=1 -> o_data_y=X. H=0 -> o_data_y=0.
- Reset mid-operation: assert i_reset 5 cycles into MULT -> no o_valid, o_ready=1 the cycle after reset deasserts, o_data_y=0. A subsequent single-block message gives the expected value.
- NB_DIGIT sweep 1/4/32 on the two-block case -> identical result; o_valid at accept_last+128/+32/+4 cycles +1.
- With GHASH_BUSY_ERROR_EN: pulse i_valid during MULT -> o_error=1, stays 1 until reset; without the macro, o_error is absent and the result is unaffected.
